spmm_sched: RTL and testbench
=============================

Name: spmm_sched

Overview:
Job-level sequencer for the SpMM core. It accepts job descriptors from the host queue and runs each job through four phases: RHS load beats, LHS issue in the correct ns/ws/os/wos mode, compute wait, and output drain beats. It tracks weight-stationary RHS reuse and output-stationary accumulation across consecutive jobs. It sits between the host command queue and the SpMM core's start/ready handshakes.

Parameters:
N, 16, matrix dimension; must be a multiple of 4.
BEATS, N/4, number of 4-row beats per RHS load and per output drain.
TIMEOUT, 1024, maximum cycles spent waiting on any core ready signal.
CNT_W, 16, width of job_count.

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous reset, active-low (0 = reset asserted).
job_valid  in  1  job descriptor present.
job_ready  out  1  scheduler accepts a descriptor; transfer occurs when job_valid && job_ready.
job_ws  in  1  keep this job's RHS for the next job.
job_os  in  1  accumulate this job into the previous output.
job_drain  in  1  drain the output after this job.
rhs_start  out  1  one-cycle pulse to core on RHS beat 0.
rhs_beat  out  1  RHS beat strobe to the upstream RHS source.
rhs_beat_idx  out  $clog2(BEATS)  current RHS beat index.
core_lhs_ready_ns, core_lhs_ready_ws, core_lhs_ready_os, core_lhs_ready_wos  in  1 each  core LHS readiness per mode.
lhs_start  out  1  one-cycle pulse to core.
lhs_ws  out  1  mode bit, valid with lhs_start.
lhs_os  out  1  mode bit, valid with lhs_start.
core_out_ready  in  1  core result available.
out_start  out  1  one-cycle pulse to core on drain beat 0.
out_beat_valid  out  1  drain beat strobe to the downstream sink.
out_beat_idx  out  $clog2(BEATS)  current drain beat index.
busy  out  1  FSM not in IDLE.
done  out  1  one-cycle pulse when a job retires.
err_timeout  out  1  sticky timeout error flag.
job_count  out  CNT_W  number of retired jobs; wraps.

Behaviour:
- Reset (reset==0, async): state=IDLE. All outputs 0 except job_ready=1. rhs_held=0, acc_pending=0, counters=0, err_timeout=0.
- Reset asserted mid-job: the job is aborted immediately. No further pulses are issued and no done pulse is produced.
- All outputs are registered.
- FSM states: IDLE, LOAD, ISSUE, COMPUTE, DRAIN, RETIRE.
- IDLE:
  - job_ready=1 (and 0 in every other state).
  - On handshake, latch ws, os, drain.
  - Go to ISSUE if rhs_held=1, else go to LOAD.
- LOAD (exactly BEATS cycles):
  - rhs_beat=1 and rhs_beat_idx=0..BEATS-1.
  - rhs_start=1 only on idx 0.
  - Then go to ISSUE.
- ISSUE:
  - Mode: lhs_ws = rhs_held, lhs_os = latched os && acc_pending.
  - Wait for the core ready that matches {lhs_ws, lhs_os}: 00→ns, 10→ws, 01→os, 11→wos.
  - On the cycle the matching ready is seen, pulse lhs_start for one cycle together with lhs_ws/lhs_os, then go to COMPUTE.
  - Non-matching readies are ignored.
- COMPUTE: wait for core_out_ready=1.
  - If the latched drain=1, go to DRAIN.
  - Otherwise go to RETIRE, with acc_pending=1.
- DRAIN (exactly BEATS cycles):
  - out_beat_valid=1 and out_beat_idx=0..BEATS-1.
  - out_start=1 only on idx 0.
  - There is no backpressure.
  - Then set acc_pending=0 and go to RETIRE.
- RETIRE (1 cycle):
  - done=1, job_count+=1.
  - rhs_held = latched ws.
  - Return to IDLE.
- os requested with acc_pending=0: lhs_os is forced to 0, since there is no prior output to accumulate into.
- Timeout:
  - A wait counter clears on entry to ISSUE and to COMPUTE, and increments each waiting cycle.
  - When it reaches TIMEOUT-1 without the awaited ready: set err_timeout=1, clear rhs_held and acc_pending, go to IDLE.
  - No done pulse and no job_count increment.
  - err_timeout clears only on reset.
- A ready arriving on the same cycle the counter hits TIMEOUT-1 takes priority: it is a normal advance.
- Latency from job handshake to done:
  - No load, no drain: 1 (ISSUE entry) + ready wait + 1 + out_ready wait + 1.
  - LOAD adds BEATS cycles; DRAIN adds BEATS cycles.
- The beat index wraps to 0 after BEATS-1.
- job_count wraps at 2^CNT_W.

Test Plan:
- Reset, then ns job (ws=0, os=0, drain=1), with core_lhs_ready_ns raised 3 cycles into ISSUE and core_out_ready raised 5 cycles after lhs_start → expect the following, with done 1 cycle after the last drain beat and job_count=1:
  - rhs_beat idx 0,1,2,3 with rhs_start on idx 0;
  - one lhs_start with ws=0, os=0;
  - out beat idx 0..3 with out_start on idx 0.
- Job A (ws=1, drain=1) then job B (ws=0) → job B has no LOAD beats and issues lhs_start with lhs_ws=1; a job C after B performs LOAD again.
- Job A (drain=0) then job B (os=1, drain=1) → job A has no DRAIN and its done pulse follows out_ready by 1 cycle; job B issues lhs_os=1, and a single drain occurs, after job B.
- First job after reset with os=1 → lhs_os=0, and the bench checks that the ns ready is the one awaited.
- core_lhs_ready_ws held high while ns is awaited, with no ns ready ever raised → after TIMEOUT cycles err_timeout=1, busy=0, no done, job_count unchanged; err_timeout stays high until reset.
- reset driven low during DRAIN beat 2 → outputs are cleared asynchronously in the same cycle, with job_ready=1; no done; the next job after release starts with LOAD.

Source files
------------

// File: rtl/spmm_sched.sv
// Job-level sequencer for the SpMM core: RHS load beats, LHS issue, compute wait, output drain.
// Tracks weight-stationary RHS reuse and output-stationary accumulation across consecutive jobs.
module spmm_sched #(
  parameter int unsigned N       = 16,
  parameter int unsigned BEATS   = N / 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic                     job_ws,
  input  logic                     job_os,
  input  logic                     job_drain,
  output logic                     rhs_start,
  output logic                     rhs_beat,
  output logic [$clog2(BEATS)-1:0] rhs_beat_idx,
  input  logic                     core_lhs_ready_ns,
  input  logic                     core_lhs_ready_ws,
  input  logic                     core_lhs_ready_os,
  input  logic                     core_lhs_ready_wos,
  output logic                     lhs_start,
  output logic                     lhs_ws,
  output logic                     lhs_os,
  input  logic                     core_out_ready,
  output logic                     out_start,
  output logic                     out_beat_valid,
  output logic [$clog2(BEATS)-1:0] out_beat_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     err_timeout,
  output logic [CNT_W-1:0]         job_count
);

  localparam int unsigned IDX_W  = $clog2(BEATS);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_BEAT = IDX_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_COMPUTE, S_DRAIN, S_RETIRE
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                ws_q, ws_d, os_q, os_d, drain_q, drain_d;
  logic                rhs_held_q, rhs_held_d, acc_pending_q, acc_pending_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                job_ready_q, job_ready_d, busy_q, busy_d, done_q, done_d;
  logic                rhs_start_q, rhs_start_d, rhs_beat_q, rhs_beat_d;
  logic [IDX_W-1:0]    rhs_idx_q, rhs_idx_d, out_idx_q, out_idx_d;
  logic                lhs_start_q, lhs_start_d, lhs_ws_q, lhs_ws_d, lhs_os_q, lhs_os_d;
  logic                out_start_q, out_start_d, out_beat_q, out_beat_d;
  logic                mode_ws, mode_os, lhs_rdy;

  // Issue mode: RHS reuse when held, accumulate only if a prior output is pending.
  assign mode_ws = rhs_held_q;
  assign mode_os = os_q && acc_pending_q;

  always_comb begin
    lhs_rdy = core_lhs_ready_ns;
    case ({mode_ws, mode_os})
      2'b10:   lhs_rdy = core_lhs_ready_ws;
      2'b01:   lhs_rdy = core_lhs_ready_os;
      2'b11:   lhs_rdy = core_lhs_ready_wos;
      default: lhs_rdy = core_lhs_ready_ns;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = '0;
    wait_d        = '0;
    ws_d          = ws_q;
    os_d          = os_q;
    drain_d       = drain_q;
    rhs_held_d    = rhs_held_q;
    acc_pending_d = acc_pending_q;
    err_d         = err_q;
    count_d       = count_q;
    lhs_start_d   = 1'b0;
    lhs_ws_d      = 1'b0;
    lhs_os_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (job_valid && job_ready_q) begin
          ws_d    = job_ws;
          os_d    = job_os;
          drain_d = job_drain;
          state_d = rhs_held_q ? S_ISSUE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (beat_q == LAST_BEAT) state_d = S_ISSUE;
        else                     beat_d  = beat_q + 1'b1;
      end
      S_ISSUE: begin
        if (lhs_rdy) begin
          lhs_start_d = 1'b1;
          lhs_ws_d    = mode_ws;
          lhs_os_d    = mode_os;
          state_d     = S_COMPUTE;
        end else if (wait_q == LAST_WAIT) begin
          err_d         = 1'b1;
          rhs_held_d    = 1'b0;
          acc_pending_d = 1'b0;
          state_d       = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_COMPUTE: begin
        if (core_out_ready) begin
          if (drain_q) begin
            state_d = S_DRAIN;
          end else begin
            acc_pending_d = 1'b1;
            state_d       = S_RETIRE;
          end
        end else if (wait_q == LAST_WAIT) begin
          err_d         = 1'b1;
          rhs_held_d    = 1'b0;
          acc_pending_d = 1'b0;
          state_d       = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (beat_q == LAST_BEAT) begin
          acc_pending_d = 1'b0;
          state_d       = S_RETIRE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_RETIRE: begin
        rhs_held_d = ws_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of what the next state implies.
    done_d      = (state_d == S_RETIRE);
    if (done_d) count_d = count_q + 1'b1;
    job_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rhs_beat_d  = (state_d == S_LOAD);
    rhs_start_d = rhs_beat_d && (beat_d == '0);
    rhs_idx_d   = rhs_beat_d ? beat_d : '0;
    out_beat_d  = (state_d == S_DRAIN);
    out_start_d = out_beat_d && (beat_d == '0);
    out_idx_d   = out_beat_d ? beat_d : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      wait_q        <= '0;
      ws_q          <= 1'b0;
      os_q          <= 1'b0;
      drain_q       <= 1'b0;
      rhs_held_q    <= 1'b0;
      acc_pending_q <= 1'b0;
      err_q         <= 1'b0;
      count_q       <= '0;
      job_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rhs_start_q   <= 1'b0;
      rhs_beat_q    <= 1'b0;
      rhs_idx_q     <= '0;
      lhs_start_q   <= 1'b0;
      lhs_ws_q      <= 1'b0;
      lhs_os_q      <= 1'b0;
      out_start_q   <= 1'b0;
      out_beat_q    <= 1'b0;
      out_idx_q     <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      wait_q        <= wait_d;
      ws_q          <= ws_d;
      os_q          <= os_d;
      drain_q       <= drain_d;
      rhs_held_q    <= rhs_held_d;
      acc_pending_q <= acc_pending_d;
      err_q         <= err_d;
      count_q       <= count_d;
      job_ready_q   <= job_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rhs_start_q   <= rhs_start_d;
      rhs_beat_q    <= rhs_beat_d;
      rhs_idx_q     <= rhs_idx_d;
      lhs_start_q   <= lhs_start_d;
      lhs_ws_q      <= lhs_ws_d;
      lhs_os_q      <= lhs_os_d;
      out_start_q   <= out_start_d;
      out_beat_q    <= out_beat_d;
      out_idx_q     <= out_idx_d;
    end
  end

  assign job_ready      = job_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_timeout    = err_q;
  assign job_count      = count_q;
  assign rhs_start      = rhs_start_q;
  assign rhs_beat       = rhs_beat_q;
  assign rhs_beat_idx   = rhs_idx_q;
  assign lhs_start      = lhs_start_q;
  assign lhs_ws         = lhs_ws_q;
  assign lhs_os         = lhs_os_q;
  assign out_start      = out_start_q;
  assign out_beat_valid = out_beat_q;
  assign out_beat_idx   = out_idx_q;

endmodule

// File: tb/tb_spmm_sched.sv
// Self-checking bench for spmm_sched: per-job cycle timeline reference model with randomized
// readiness noise, plus timeout, first-job accumulate and mid-drain reset scenarios.
module tb_spmm_sched;
  localparam int B  = 4;
  localparam int TO = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        job_valid, job_ready, job_ws, job_os, job_drain;
  logic        rhs_start, rhs_beat;
  logic [1:0]  rhs_beat_idx, out_beat_idx;
  logic        core_lhs_ready_ns, core_lhs_ready_ws, core_lhs_ready_os, core_lhs_ready_wos;
  logic        lhs_start, lhs_ws, lhs_os, core_out_ready;
  logic        out_start, out_beat_valid, busy, done, err_timeout;
  logic [15:0] job_count;

  always #5 clock = ~clock;

  spmm_sched #(.N(16), .BEATS(B), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_ws(job_ws), .job_os(job_os), .job_drain(job_drain),
    .rhs_start(rhs_start), .rhs_beat(rhs_beat), .rhs_beat_idx(rhs_beat_idx),
    .core_lhs_ready_ns(core_lhs_ready_ns), .core_lhs_ready_ws(core_lhs_ready_ws),
    .core_lhs_ready_os(core_lhs_ready_os), .core_lhs_ready_wos(core_lhs_ready_wos),
    .lhs_start(lhs_start), .lhs_ws(lhs_ws), .lhs_os(lhs_os),
    .core_out_ready(core_out_ready),
    .out_start(out_start), .out_beat_valid(out_beat_valid), .out_beat_idx(out_beat_idx),
    .busy(busy), .done(done), .err_timeout(err_timeout), .job_count(job_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state carried between jobs.
  logic        m_held, m_acc, m_err;
  logic [15:0] m_count;

  // Matching ready follows match_hi; the other three are noise (or all high).
  task automatic drive_readies(input logic mws, input logic mos, input logic match_hi,
                               input logic all_hi);
    logic [3:0] r;
    int sel;
    r   = all_hi ? 4'hF : 4'($urandom);
    sel = mws ? (mos ? 3 : 1) : (mos ? 2 : 0);
    r[sel] = match_hi;
    core_lhs_ready_ns  = r[0];
    core_lhs_ready_ws  = r[1];
    core_lhs_ready_os  = r[2];
    core_lhs_ready_wos = r[3];
  endtask

  task automatic model_reset();
    m_held = 1'b0; m_acc = 1'b0; m_err = 1'b0; m_count = '0;
  endtask

  task automatic test_reset();
    logic [15:0] act;
    @(negedge clock);
    reset = 1'b0;
    #1;
    act = {rhs_start, rhs_beat, rhs_beat_idx, lhs_start, lhs_ws, lhs_os, out_start,
           out_beat_valid, out_beat_idx, busy, done, err_timeout, job_ready, 1'b0};
    n_cmp++;
    if (act !== 16'h0002 || job_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs act=%h cnt=%h exp=0002 cnt=0000", act, job_count);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    model_reset();
  endtask

  // Runs one job against a timeline derived from the phase rules:
  // optional LOAD (B), ISSUE until ready, COMPUTE until out_ready, optional DRAIN (B), RETIRE.
  task automatic run_job(input logic ws, input logic os, input logic drain, input int ld,
                         input int od, input int abort_beat, input logic all_hi);
    logic        load, mws, mos;
    int          c_i, c_c, c_d, c_done, c_abort;
    logic [14:0] e, a;
    logic        e_ls;
    load   = !m_held;
    mws    = m_held;
    mos    = os && m_acc;
    c_i    = load ? B : 0;
    c_c    = c_i + ld + 1;
    c_d    = c_c + od + 1;
    c_done = drain ? c_d + B : c_c + od + 1;
    c_abort = (abort_beat >= 0) ? c_d + abort_beat : -1;

    job_valid = 1'b1; job_ws = ws; job_os = os; job_drain = drain;
    drive_readies(mws, mos, 1'b0, all_hi);
    core_out_ready = 1'($urandom);
    @(negedge clock);
    n_cmp++;
    if (job_ready !== 1'b1 || busy !== 1'b0 || job_count !== m_count) begin
      n_fail++;
      $display("FAIL idle_before_job ready=%b busy=%b cnt=%0d exp ready=1 busy=0 cnt=%0d",
               job_ready, busy, job_count, m_count);
    end
    @(posedge clock); #1;

    for (int c = 0; c <= c_done; c++) begin
      job_valid = 1'($urandom);
      job_ws = 1'($urandom); job_os = 1'($urandom); job_drain = 1'($urandom);
      drive_readies(mws, mos, c == c_i + ld, all_hi);
      if (c >= c_c && c < c_c + od) core_out_ready = 1'b0;
      else if (c == c_c + od)       core_out_ready = 1'b1;
      else                          core_out_ready = 1'($urandom);
      @(negedge clock);
      e_ls = (c == c_c);
      e = {load && c < B, load && c == 0, (load && c < B) ? 2'(c) : 2'b00,
           e_ls, e_ls && mws, e_ls && mos,
           drain && c >= c_d && c < c_d + B, drain && c == c_d,
           (drain && c >= c_d && c < c_d + B) ? 2'(c - c_d) : 2'b00,
           c == c_done, 1'b1, 1'b0, m_err};
      a = {rhs_beat, rhs_start, rhs_beat_idx, lhs_start, e_ls ? lhs_ws : 1'b0,
           e_ls ? lhs_os : 1'b0, out_beat_valid, out_start, out_beat_idx,
           done, busy, job_ready, err_timeout};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL job_cycle c=%0d ws=%b os=%b dr=%b act=%h exp=%h", c, ws, os, drain, a, e);
      end
      if (c == c_abort) begin
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({out_beat_valid, out_start, out_beat_idx, busy, done, job_ready, err_timeout}
            !== 8'b0000_0010 || job_count !== 16'h0) begin
          n_fail++;
          $display("FAIL async_reset_clear ob=%b os=%b idx=%0d busy=%b done=%b rdy=%b cnt=%0d exp rdy=1 rest 0",
                   out_beat_valid, out_start, out_beat_idx, busy, done, job_ready, job_count);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_no_done done=%b busy=%b rdy=%b exp 0 0 1", done, busy, job_ready);
        end
        job_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        model_reset();
        return;
      end
      @(posedge clock); #1;
    end

    job_valid = 1'b0;
    m_count = m_count + 16'd1;
    m_held  = ws;
    m_acc   = !drain;
    n_cmp++;
    if (job_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || job_count !== m_count) begin
      n_fail++;
      $display("FAIL retire_to_idle ready=%b busy=%b done=%b cnt=%0d exp 1 0 0 cnt=%0d",
               job_ready, busy, done, job_count, m_count);
    end
  endtask

  task automatic test_ns_basic();
    run_job(1'b0, 1'b0, 1'b1, 3, 5, -1, 1'b0);
  endtask

  task automatic test_ws_reuse();
    run_job(1'b1, 1'b0, 1'b1, 1, 2, -1, 1'b0);
    run_job(1'b0, 1'b0, 1'b1, 2, 1, -1, 1'b0);
    run_job(1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
  endtask

  task automatic test_os_accum();
    run_job(1'b0, 1'b0, 1'b0, 2, 3, -1, 1'b0);
    run_job(1'b0, 1'b1, 1'b1, 1, 4, -1, 1'b0);
  endtask

  task automatic test_first_os();
    test_reset();
    run_job(1'b0, 1'b1, 1'b1, 4, 2, -1, 1'b1);
  endtask

  task automatic test_back_to_back_random();
    for (int j = 0; j < 25; j++)
      run_job(1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), -1, 1'b0);
  endtask

  task automatic test_timeout();
    int dn, ls;
    test_reset();
    job_valid = 1'b1; job_ws = 1'b0; job_os = 1'b0; job_drain = 1'b0;
    @(negedge clock);
    @(posedge clock); #1;
    job_valid = 1'b0;
    dn = 0; ls = 0;
    for (int c = 0; c <= B + TO; c++) begin
      core_lhs_ready_ns  = 1'b0;
      core_lhs_ready_ws  = 1'b1;
      core_lhs_ready_os  = 1'($urandom);
      core_lhs_ready_wos = 1'($urandom);
      core_out_ready     = 1'($urandom);
      @(negedge clock);
      if (done)      dn++;
      if (lhs_start) ls++;
      if (c == B + TO - 1) begin
        n_cmp++;
        if ({busy, err_timeout} !== 2'b10) begin
          n_fail++;
          $display("FAIL timeout_last_wait busy=%b err=%b exp busy=1 err=0", busy, err_timeout);
        end
      end
      if (c == B + TO) begin
        n_cmp++;
        if ({busy, err_timeout, job_ready} !== 3'b011) begin
          n_fail++;
          $display("FAIL timeout_fire busy=%b err=%b rdy=%b exp 0 1 1", busy, err_timeout, job_ready);
        end
      end
      @(posedge clock); #1;
    end
    n_cmp++;
    if (dn != 0 || ls != 0 || job_count !== m_count) begin
      n_fail++;
      $display("FAIL timeout_no_retire done=%0d lhs=%0d cnt=%0d exp 0 0 cnt=%0d",
               dn, ls, job_count, m_count);
    end
    m_err = 1'b1; m_held = 1'b0; m_acc = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    n_cmp++;
    if (err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky err=%b exp 1", err_timeout);
    end
    run_job(1'b1, 1'b0, 1'b0, 1, 1, -1, 1'b0);
    test_reset();
  endtask

  task automatic test_reset_mid_drain();
    run_job(1'b1, 1'b0, 1'b0, 1, 1, -1, 1'b0);
    run_job(1'b1, 1'b1, 1'b1, 2, 2, 2, 1'b0);
    run_job(1'b0, 1'b0, 1'b1, 1, 1, -1, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    job_valid = 1'b0; job_ws = 1'b0; job_os = 1'b0; job_drain = 1'b0;
    core_lhs_ready_ns = 1'b0; core_lhs_ready_ws = 1'b0;
    core_lhs_ready_os = 1'b0; core_lhs_ready_wos = 1'b0;
    core_out_ready = 1'b0;
    model_reset();
    test_reset();
    test_ns_basic();
    test_ws_reuse();
    test_os_accum();
    test_first_os();
    test_back_to_back_random();
    test_timeout();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
